// File: rtl/palette_dac_regs_if.sv
// CPU-side loader bus of the palette DAC: index/data strobes, byte data, busy and palette select.
interface palette_dac_regs_if #(
  parameter int NUM_PALETTES = 2
);
  localparam int PW = $clog2(NUM_PALETTES);

  logic          cpu_idx_we;
  logic          cpu_data_we;
  logic          cpu_data_re;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_busy;
  logic [PW-1:0] cpu_pal_edit;

  modport master (
    output cpu_idx_we, cpu_data_we, cpu_data_re, cpu_din, cpu_pal_edit,
    input  cpu_dout, cpu_busy
  );

  modport slave (
    input  cpu_idx_we, cpu_data_we, cpu_data_re, cpu_din, cpu_pal_edit,
    output cpu_dout, cpu_busy
  );
endinterface

// File: rtl/palette_dac_regs.sv
// Multi-palette colour lookup RAM with a sequential R/G/B CPU loader and a
// 2-stage pipelined pixel lookup port; active palette switches only on frame_start.
module palette_dac_regs #(
  parameter int NUM_PALETTES = 2,
  parameter int NUM_COLORS   = 16,
  parameter int COMP_WIDTH   = 4,
  localparam int PW    = $clog2(NUM_PALETTES),
  localparam int CW    = $clog2(NUM_COLORS),
  localparam int RW    = 3 * COMP_WIDTH,
  localparam int DEPTH = NUM_PALETTES * NUM_COLORS
) (
  input  logic                 clk,
  input  logic                 rst,
  palette_dac_regs_if.slave    cpu,
  input  logic [PW-1:0]        pal_req,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [CW-1:0]        pix_color,
  output logic [RW-1:0]        pix_rgb,
  output logic                 pix_rgb_valid
);

  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

  logic [RW-1:0]         mem [0:DEPTH-1];
  logic [RW-1:0]         pre_q;
  logic [RW-1:0]         pix_q;
  logic                  pix_v1;

  phase_t                phase;
  logic [CW-1:0]         idx;
  logic [COMP_WIDTH-1:0] stg_r;
  logic [COMP_WIDTH-1:0] stg_g;
  logic                  busy;
  logic [7:0]            dout;
  logic [PW-1:0]         pal_active;

  logic                  commit;
  logic [RW-1:0]         wdata;
  logic [COMP_WIDTH-1:0] din_comp;
  logic [COMP_WIDTH-1:0] rd_comp;
  logic                  unused_din;

  always_comb begin
    din_comp   = cpu.cpu_din[COMP_WIDTH-1:0];
    unused_din = ^cpu.cpu_din;
    commit     = !rst && !busy && !cpu.cpu_idx_we && cpu.cpu_data_we && (phase == PH_B);
    wdata      = {stg_r, stg_g, din_comp};
    case (phase)
      PH_R:    rd_comp = pre_q[RW-1 -: COMP_WIDTH];
      PH_G:    rd_comp = pre_q[2*COMP_WIDTH-1 -: COMP_WIDTH];
      default: rd_comp = pre_q[COMP_WIDTH-1:0];
    endcase
    cpu.cpu_busy = busy;
    cpu.cpu_dout = dout;
  end

  // Block RAM: no reset; both reads are read-first against a same-edge commit.
  always_ff @(posedge clk) begin
    if (commit)
      mem[{cpu.cpu_pal_edit, idx}] <= wdata;
    pre_q <= mem[{cpu.cpu_pal_edit, idx}];
    pix_q <= mem[{pal_active, pix_color}];
  end

  // Loader FSM. Every index change raises busy for one cycle so that pre_q
  // reflects the new address before the next strobe is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_R;
      idx        <= '0;
      stg_r      <= '0;
      stg_g      <= '0;
      busy       <= 1'b1;
      dout       <= '0;
      pal_active <= '0;
    end else begin
      busy <= 1'b0;
      if (frame_start)
        pal_active <= pal_req;
      if (!busy) begin
        if (cpu.cpu_idx_we) begin
          idx   <= cpu.cpu_din[CW-1:0];
          phase <= PH_R;
          stg_r <= '0;
          stg_g <= '0;
          busy  <= 1'b1;
        end else if (cpu.cpu_data_we) begin
          case (phase)
            PH_R: begin
              stg_r <= din_comp;
              phase <= PH_G;
            end
            PH_G: begin
              stg_g <= din_comp;
              phase <= PH_B;
            end
            default: begin
              idx   <= idx + 1'b1;
              phase <= PH_R;
              busy  <= 1'b1;
            end
          endcase
        end else if (cpu.cpu_data_re) begin
          dout <= 8'(rd_comp);
          case (phase)
            PH_R:    phase <= PH_G;
            PH_G:    phase <= PH_B;
            default: begin
              idx   <= idx + 1'b1;
              phase <= PH_R;
              busy  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_v1        <= 1'b0;
      pix_rgb       <= '0;
      pix_rgb_valid <= 1'b0;
    end else begin
      pix_v1        <= pix_valid;
      pix_rgb_valid <= pix_v1;
      if (pix_v1)
        pix_rgb <= pix_q;
    end
  end

endmodule

// File: tb/tb_palette_dac_regs.sv
// Directed + randomized bench for palette_dac_regs against an entry-level
// reference model (palette RAM array, R/G/B position counter, lookup queue).
module tb_palette_dac_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  pal_req;
  logic        frame_start;
  logic        pix_valid;
  logic [3:0]  pix_color;
  logic [11:0] pix_rgb;
  logic        pix_rgb_valid;

  palette_dac_regs_if #(.NUM_PALETTES(2)) bus ();

  palette_dac_regs #(
    .NUM_PALETTES(2),
    .NUM_COLORS  (16),
    .COMP_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (bus.slave),
    .pal_req      (pal_req),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_color    (pix_color),
    .pix_rgb      (pix_rgb),
    .pix_rgb_valid(pix_rgb_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] val;
  } lookup_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  logic [11:0] ref_mem [32];
  logic [3:0]  m_stage [3];
  int          m_idx;
  int          m_pos;
  bit          m_busy;
  logic [7:0]  m_dout;
  int          m_pal_act;
  logic [11:0] m_last_rgb;
  lookup_t     m_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: derive what this edge must do from the current inputs, then check.
  task automatic tick();
    bit          nb;
    logic [11:0] e;
    int          a;
    lookup_t     l;
    nb = 1'b0;
    if (!rst && pix_valid) begin
      l.due = cyc + 2;
      l.val = ref_mem[m_pal_act * 16 + int'(pix_color)];
      m_q.push_back(l);
    end
    if (!rst && !m_busy) begin
      a = int'(bus.cpu_pal_edit) * 16 + m_idx;
      if (bus.cpu_idx_we) begin
        m_idx   = int'(bus.cpu_din[3:0]);
        m_pos   = 0;
        m_stage = '{4'h0, 4'h0, 4'h0};
        nb      = 1'b1;
      end else if (bus.cpu_data_we) begin
        m_stage[m_pos] = bus.cpu_din[3:0];
        if (m_pos == 2) begin
          ref_mem[a] = {m_stage[0], m_stage[1], m_stage[2]};
          m_idx = (m_idx + 1) % 16;
          m_pos = 0;
          nb    = 1'b1;
        end else m_pos++;
      end else if (bus.cpu_data_re) begin
        e      = ref_mem[a];
        m_dout = {4'h0, e[11 - 4*m_pos -: 4]};
        if (m_pos == 2) begin
          m_idx = (m_idx + 1) % 16;
          m_pos = 0;
          nb    = 1'b1;
        end else m_pos++;
      end
    end
    if (!rst && frame_start) m_pal_act = int'(pal_req);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_busy     = 1'b1;
      m_idx      = 0;
      m_pos      = 0;
      m_stage    = '{4'h0, 4'h0, 4'h0};
      m_dout     = 8'h00;
      m_pal_act  = 0;
      m_last_rgb = 12'h000;
      m_q.delete();
    end else m_busy = nb;
    chk("busy", 32'(bus.cpu_busy), 32'(m_busy));
    chk("dout", 32'(bus.cpu_dout), 32'(m_dout));
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      m_last_rgb = m_q[0].val;
      void'(m_q.pop_front());
      chk("pix_valid", 32'(pix_rgb_valid), 32'd1);
    end else begin
      chk("pix_valid", 32'(pix_rgb_valid), 32'd0);
    end
    chk("pix_rgb", 32'(pix_rgb), 32'(m_last_rgb));
  endtask

  // kind: 1 = index load, 2 = data write, 3 = data read
  task automatic cpu_op(input int kind, input logic [7:0] d);
    int n;
    n = 0;
    while (m_busy && n < 8) begin
      tick();
      n++;
    end
    bus.cpu_din     = d;
    bus.cpu_idx_we  = (kind == 1);
    bus.cpu_data_we = (kind == 2);
    bus.cpu_data_re = (kind == 3);
    tick();
    bus.cpu_idx_we  = 1'b0;
    bus.cpu_data_we = 1'b0;
    bus.cpu_data_re = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    pal_req          = 1'b0;
    frame_start      = 1'b0;
    pix_valid        = 1'b0;
    pix_color        = 4'h0;
    bus.cpu_idx_we   = 1'b0;
    bus.cpu_data_we  = 1'b0;
    bus.cpu_data_re  = 1'b0;
    bus.cpu_din      = 8'h00;
    bus.cpu_pal_edit = 1'b0;
    m_busy = 1'b1; m_idx = 0; m_pos = 0; m_dout = 8'h00; m_pal_act = 0; m_last_rgb = 12'h000;
    m_stage = '{4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 32; i++) ref_mem[i] = 12'h000;

    tick();
    tick();
    chk("reset_busy", 32'(bus.cpu_busy), 32'd1);
    chk("reset_dout", 32'(bus.cpu_dout), 32'd0);
    rst = 1'b0;

    // Fill both palettes through the auto-incrementing loader (index wraps after 15).
    for (int p = 0; p < 2; p++) begin
      bus.cpu_pal_edit = 1'(p);
      cpu_op(1, 8'h00);
      for (int k = 0; k < 48; k++) cpu_op(2, 8'($urandom));
    end

    // Step 1: entry {0,5} = A3C, index moves to 6.
    bus.cpu_pal_edit = 1'b0;
    cpu_op(1, 8'h05);
    cpu_op(2, 8'hFA);
    cpu_op(2, 8'h33);
    cpu_op(2, 8'h0C);
    cpu_op(3, 8'h00);

    // Step 2: entry {1,15} = 123, then index wraps to 0.
    bus.cpu_pal_edit = 1'b1;
    cpu_op(1, 8'h0F);
    cpu_op(2, 8'h01);
    cpu_op(2, 8'h02);
    cpu_op(2, 8'h03);
    cpu_op(3, 8'h00);

    // Step 3: read back {0,5} component by component.
    bus.cpu_pal_edit = 1'b0;
    cpu_op(1, 8'h05);
    cpu_op(3, 8'h00);
    chk("s3_r", 32'(bus.cpu_dout), 32'h0A);
    cpu_op(3, 8'h00);
    chk("s3_g", 32'(bus.cpu_dout), 32'h03);
    cpu_op(3, 8'h00);
    chk("s3_b", 32'(bus.cpu_dout), 32'h0C);
    cpu_op(3, 8'h00);

    // Step 4: pixel latency and tear-free palette swap.
    pix_valid = 1'b1; pix_color = 4'h5;
    tick();
    pix_valid = 1'b0;
    tick();
    chk("s4_pix_lat_v", 32'(pix_rgb_valid), 32'd1);
    chk("s4_pix_lat", 32'(pix_rgb), 32'hA3C);
    pal_req = 1'b1;
    pix_valid = 1'b1; pix_color = 4'hF;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    chk("s4_new_pal", 32'(pix_rgb), 32'h123);

    // Step 5: same-edge commit and lookup of {0,5} is read-first.
    pal_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bus.cpu_pal_edit = 1'b0;
    cpu_op(1, 8'h05);
    cpu_op(2, 8'h0F);
    cpu_op(2, 8'h0F);
    while (m_busy) tick();
    bus.cpu_din = 8'h0F; bus.cpu_data_we = 1'b1;
    pix_valid = 1'b1; pix_color = 4'h5;
    tick();
    bus.cpu_data_we = 1'b0;
    tick();
    pix_valid = 1'b0;
    chk("s5_old", 32'(pix_rgb), 32'hA3C);
    tick();
    chk("s5_new", 32'(pix_rgb), 32'hFFF);

    // Step 6: aborted sequences, reset mid-entry, strobes while busy.
    cpu_op(1, 8'h01);
    cpu_op(2, 8'h07);
    cpu_op(2, 8'h07);
    cpu_op(1, 8'h02);
    chk("s6_busy", 32'(bus.cpu_busy), 32'd1);
    bus.cpu_din = 8'h09; bus.cpu_data_we = 1'b1; bus.cpu_data_re = 1'b1;
    tick();
    bus.cpu_data_we = 1'b0; bus.cpu_data_re = 1'b0;
    for (int k = 0; k < 3; k++) cpu_op(3, 8'h00);
    cpu_op(1, 8'h01);
    for (int k = 0; k < 3; k++) cpu_op(3, 8'h00);
    cpu_op(1, 8'h09);
    cpu_op(2, 8'h0E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_rst_dout", 32'(bus.cpu_dout), 32'd0);
    cpu_op(1, 8'h09);
    for (int k = 0; k < 3; k++) cpu_op(3, 8'h00);

    // Randomized traffic on both ports, including simultaneous strobes.
    for (int c = 0; c < 600; c++) begin
      pix_valid   = 1'($urandom_range(0, 1));
      pix_color   = 4'($urandom);
      pal_req     = 1'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      bus.cpu_din     = 8'($urandom);
      bus.cpu_idx_we  = ($urandom_range(0, 9) == 0);
      bus.cpu_data_we = 1'($urandom_range(0, 1));
      bus.cpu_data_re = 1'($urandom_range(0, 1));
      if (!m_busy && bus.cpu_idx_we) bus.cpu_pal_edit = 1'($urandom);
      tick();
    end
    pix_valid = 1'b0; frame_start = 1'b0;
    bus.cpu_idx_we = 1'b0; bus.cpu_data_we = 1'b0; bus.cpu_data_re = 1'b0;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
